uart_rx_frame_ctrl: RTL and testbench

Frame controller sitting directly behind the UART receiver. It consumes the receiver's one-cycle byte strobe and byte value, locks onto a sync byte, reads a length byte, forwards the payload bytes with their index, and optionally checks a trailing checksum. It reports each frame as complete or failed, with an error code, and supervises inter-byte gaps with a timeout so a stalled link cannot wedge it mid-frame.

---
 rtl/uart_rx_frame_ctrl.sv | 161 ++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller behind the UART receiver: SYNC, LEN, payload[, checksum with UART_FRAME_CHECKSUM_EN].
// Latency: every response is registered and appears one clk after the rx_done strobe.
// Backpressure: none; back-to-back strobes are accepted, and an inter-byte gap timeout aborts a stalled frame.
module uart_rx_frame_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter logic [DATA_WIDTH-1:0] SYNC_BYTE = 8'hA5,
    parameter int MAX_LEN      = 16,
    parameter int TIMEOUT_CLKS = 1000,
    localparam int IDX_W       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  rx_done,
    input  logic [DATA_WIDTH-1:0] rx_byte,
    output logic                  pl_valid,
    output logic [DATA_WIDTH-1:0] pl_data,
    output logic [IDX_W-1:0]      pl_index,
    output logic [DATA_WIDTH-1:0] pl_len,
    output logic                  frame_ok,
    output logic                  frame_err,
    output logic [1:0]            err_code,
    output logic                  busy
);
    localparam int CNT_W = $clog2(TIMEOUT_CLKS + 1);
    // Error fires on the edge where the gap counter would step to TIMEOUT_CLKS-1.
    localparam logic [CNT_W-1:0]      GAP_LAST  = CNT_W'(TIMEOUT_CLKS - 2);
    localparam logic [DATA_WIDTH-1:0] MAX_LEN_V = DATA_WIDTH'(MAX_LEN);

    typedef enum logic [1:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHECK} state_t;

    state_t                state, state_nxt;
    logic [IDX_W-1:0]      idx, idx_nxt;
    logic [CNT_W-1:0]      gap_cnt, gap_nxt;
    logic                  pl_valid_nxt, frame_ok_nxt, frame_err_nxt;
    logic [DATA_WIDTH-1:0] pl_data_nxt, pl_len_nxt;
    logic [IDX_W-1:0]      pl_index_nxt;
    logic [1:0]            err_code_nxt;
`ifdef UART_FRAME_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum, sum_nxt;
`endif

    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        pl_valid_nxt  = 1'b0;
        pl_data_nxt   = pl_data;
        pl_index_nxt  = pl_index;
        pl_len_nxt    = pl_len;
        frame_ok_nxt  = 1'b0;
        frame_err_nxt = 1'b0;
        err_code_nxt  = err_code;
`ifdef UART_FRAME_CHECKSUM_EN
        sum_nxt       = sum;
`endif
        gap_nxt = (rx_done || state == S_IDLE) ? '0 : gap_cnt + 1'b1;

        case (state)
            S_IDLE: begin
                if (rx_done && rx_byte == SYNC_BYTE) begin
                    state_nxt = S_LEN;
`ifdef UART_FRAME_CHECKSUM_EN
                    sum_nxt   = '0;
`endif
                end
            end
            S_LEN: begin
                if (rx_done) begin
                    pl_len_nxt = rx_byte;
`ifdef UART_FRAME_CHECKSUM_EN
                    sum_nxt    = rx_byte;
`endif
                    if (rx_byte == '0 || rx_byte > MAX_LEN_V) begin
                        frame_err_nxt = 1'b1;
                        err_code_nxt  = 2'd1;
                        state_nxt     = S_IDLE;
                    end else begin
                        idx_nxt   = '0;
                        state_nxt = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (rx_done) begin
                    pl_valid_nxt = 1'b1;
                    pl_data_nxt  = rx_byte;
                    pl_index_nxt = idx;
                    idx_nxt      = idx + 1'b1;
`ifdef UART_FRAME_CHECKSUM_EN
                    sum_nxt      = sum + rx_byte;
`endif
                    if (DATA_WIDTH'(idx) == pl_len - DATA_WIDTH'(1)) begin
`ifdef UART_FRAME_CHECKSUM_EN
                        state_nxt    = S_CHECK;
`else
                        frame_ok_nxt = 1'b1;
                        state_nxt    = S_IDLE;
`endif
                    end
                end
            end
            S_CHECK: begin
`ifdef UART_FRAME_CHECKSUM_EN
                if (rx_done) begin
                    if (rx_byte == sum) begin
                        frame_ok_nxt = 1'b1;
                    end else begin
                        frame_err_nxt = 1'b1;
                        err_code_nxt  = 2'd2;
                    end
                    state_nxt = S_IDLE;
                end
`else
                state_nxt = S_IDLE;
`endif
            end
            default: state_nxt = S_IDLE;
        endcase

        // A byte arriving on the expiry cycle wins over the timeout.
        if (state != S_IDLE && !rx_done && gap_cnt == GAP_LAST) begin
            frame_err_nxt = 1'b1;
            err_code_nxt  = 2'd3;
            state_nxt     = S_IDLE;
            gap_nxt       = '0;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state     <= S_IDLE;
            idx       <= '0;
            gap_cnt   <= '0;
            pl_valid  <= 1'b0;
            pl_data   <= '0;
            pl_index  <= '0;
            pl_len    <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= 2'd0;
            busy      <= 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
            sum       <= '0;
`endif
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            gap_cnt   <= gap_nxt;
            pl_valid  <= pl_valid_nxt;
            pl_data   <= pl_data_nxt;
            pl_index  <= pl_index_nxt;
            pl_len    <= pl_len_nxt;
            frame_ok  <= frame_ok_nxt;
            frame_err <= frame_err_nxt;
            err_code  <= err_code_nxt;
            busy      <= (state_nxt != S_IDLE);
`ifdef UART_FRAME_CHECKSUM_EN
            sum       <= sum_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl: a vector table plus timeout and reset sequences.
module tb_uart_rx_frame_ctrl;
    localparam int T = 1000;

    logic       clk = 1'b0;
    logic       arst;
    logic       rx_done;
    logic [7:0] rx_byte;
    logic       pl_valid, frame_ok, frame_err, busy;
    logic [7:0] pl_data, pl_len;
    logic [3:0] pl_index;
    logic [1:0] err_code;

    uart_rx_frame_ctrl #(
        .DATA_WIDTH(8), .SYNC_BYTE(8'hA5), .MAX_LEN(16), .TIMEOUT_CLKS(T)
    ) dut (
        .clk(clk), .arst(arst), .rx_done(rx_done), .rx_byte(rx_byte),
        .pl_valid(pl_valid), .pl_data(pl_data), .pl_index(pl_index), .pl_len(pl_len),
        .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code), .busy(busy)
    );

    always #5 clk = ~clk;

    // {pl_valid, pl_data, pl_index, pl_len, frame_ok, frame_err, err_code, busy}
    logic [25:0] obs;
    assign obs = {pl_valid, pl_data, pl_index, pl_len, frame_ok, frame_err, err_code, busy};

    typedef struct {
        logic        d;
        logic [7:0]  b;
        logic [25:0] e;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

`ifdef UART_FRAME_CHECKSUM_EN
    localparam logic CS = 1'b1;
`else
    localparam logic CS = 1'b0;
`endif

    function automatic logic [25:0] pk(input logic v, input logic [7:0] dat, input logic [3:0] ix,
                                       input logic [7:0] len, input logic ok, input logic err,
                                       input logic [1:0] code, input logic bsy);
        return {v, dat, ix, len, ok, err, code, bsy};
    endfunction

    task automatic add(input logic d, input logic [7:0] b, input logic v, input logic [7:0] dat,
                       input logic [3:0] ix, input logic [7:0] len, input logic ok, input logic err,
                       input logic [1:0] code, input logic bsy);
        vec_t r;
        r.d = d;
        r.b = b;
        r.e = pk(v, dat, ix, len, ok, err, code, bsy);
        tbl.push_back(r);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic d, input logic [7:0] b);
        @(negedge clk);
        rx_done = d;
        rx_byte = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int first_err;

        arst    = 1'b1;
        rx_done = 1'b0;
        rx_byte = 8'h00;

        // Good frame A5 03 10 20 30 [63]
        add(1, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0);
        add(1, 8'hFF, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0);
        add(1, 8'hA5, 0, 8'h00, 0, 8'h00, 0, 0, 0, 1);
        add(1, 8'h03, 0, 8'h00, 0, 8'h03, 0, 0, 0, 1);
        add(1, 8'h10, 1, 8'h10, 0, 8'h03, 0, 0, 0, 1);
        add(1, 8'h20, 1, 8'h20, 1, 8'h03, 0, 0, 0, 1);
        add(1, 8'h30, 1, 8'h30, 2, 8'h03, !CS, 0, 0, CS);
        add(1, 8'h63, 0, 8'h30, 2, 8'h03, CS, 0, 0, 0);
        add(0, 8'h00, 0, 8'h30, 2, 8'h03, 0, 0, 0, 0);
        // Bad checksum A5 02 01 02 00
        add(1, 8'hA5, 0, 8'h30, 2, 8'h03, 0, 0, 0, 1);
        add(1, 8'h02, 0, 8'h30, 2, 8'h02, 0, 0, 0, 1);
        add(1, 8'h01, 1, 8'h01, 0, 8'h02, 0, 0, 0, 1);
        add(1, 8'h02, 1, 8'h02, 1, 8'h02, !CS, 0, 0, CS);
        add(1, 8'h00, 0, 8'h02, 1, 8'h02, 0, CS, CS ? 2'd2 : 2'd0, 0);
        // Length 0, length 17, then a one-byte frame
        add(1, 8'hA5, 0, 8'h02, 1, 8'h02, 0, 0, CS ? 2'd2 : 2'd0, 1);
        add(1, 8'h00, 0, 8'h02, 1, 8'h00, 0, 1, 1, 0);
        add(1, 8'hA5, 0, 8'h02, 1, 8'h00, 0, 0, 1, 1);
        add(1, 8'h11, 0, 8'h02, 1, 8'h11, 0, 1, 1, 0);
        add(1, 8'hA5, 0, 8'h02, 1, 8'h11, 0, 0, 1, 1);
        add(1, 8'h01, 0, 8'h02, 1, 8'h01, 0, 0, 1, 1);
        add(1, 8'hFF, 1, 8'hFF, 0, 8'h01, !CS, 0, 1, CS);
        // Checksum of 01+FF wraps to 00; without the checksum this byte is idle noise
        add(1, CS ? 8'h00 : 8'hFF, 0, 8'hFF, 0, 8'h01, CS, 0, 1, 0);
        // Noise, then a frame whose payload equals the sync byte
        add(1, 8'h00, 0, 8'hFF, 0, 8'h01, 0, 0, 1, 0);
        add(1, 8'hFF, 0, 8'hFF, 0, 8'h01, 0, 0, 1, 0);
        add(1, 8'hA5, 0, 8'hFF, 0, 8'h01, 0, 0, 1, 1);
        add(1, 8'h01, 0, 8'hFF, 0, 8'h01, 0, 0, 1, 1);
        add(1, 8'hA5, 1, 8'hA5, 0, 8'h01, !CS, 0, 1, CS);
        add(1, 8'hA6, 0, 8'hA5, 0, 8'h01, CS, 0, 1, 0);
        add(0, 8'h00, 0, 8'hA5, 0, 8'h01, 0, 0, 1, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 32'(obs), 32'd0);
        @(negedge clk);
        arst = 1'b0;

        foreach (tbl[i]) begin
            step(tbl[i].d, tbl[i].b);
            chk($sformatf("vec%0d", i), 32'(obs), 32'(tbl[i].e));
        end

        // Timeout with a maximum-length (16) frame stalled after its first payload byte
        step(1, 8'hA5);
        step(1, 8'h10);
        step(1, 8'h55);
        chk("to_first_byte", 32'(obs), 32'(pk(1, 8'h55, 0, 8'h10, 0, 0, 1, 1)));
        first_err = 0;
        for (int k = 1; k <= T + 4; k++) begin
            step(0, 8'h00);
            if (frame_err && first_err == 0) first_err = k;
        end
        chk("to_err_cycle", 32'(first_err), 32'(T - 1));
        chk("to_code_busy", {29'd0, err_code, busy}, {29'd0, 2'd3, 1'b0});

        // Byte on the expiry cycle wins over the timeout
        step(1, 8'hA5);
        step(1, 8'h02);
        step(1, 8'h55);
        for (int k = 1; k <= T - 2; k++) step(0, 8'h00);
        step(1, 8'h66);
        chk("to_race", 32'(obs), 32'(pk(1, 8'h66, 1, 8'h02, !CS, 0, 3, CS)));
        if (CS) begin
            step(1, 8'hBD);
            chk("to_race_ck", 32'(obs), 32'(pk(0, 8'h66, 1, 8'h02, 1, 0, 3, 0)));
        end

        // Asynchronous reset mid-frame
        step(1, 8'hA5);
        step(1, 8'h04);
        step(1, 8'h01);
        @(negedge clk);
        arst = 1'b1;
        #1;
        chk("arst_immediate", 32'(obs), 32'd0);
        step(1, 8'h02);
        chk("arst_held", 32'(obs), 32'd0);
        @(negedge clk);
        arst    = 1'b0;
        rx_done = 1'b0;
        step(1, 8'hA5);
        step(1, 8'h03);
        step(1, 8'h10);
        step(1, 8'h20);
        step(1, 8'h30);
        chk("post_arst_last", 32'(obs), 32'(pk(1, 8'h30, 2, 8'h03, !CS, 0, 0, CS)));
        if (CS) begin
            step(1, 8'h63);
            chk("post_arst_ck", 32'(obs), 32'(pk(0, 8'h30, 2, 8'h03, 1, 0, 0, 0)));
        end
        step(0, 8'h00);
        chk("post_arst_idle", 32'(obs), 32'(pk(0, 8'h30, 2, 8'h03, 0, 0, 0, 0)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
